// File: rtl/alu_exec_unit.sv
// Multi-cycle ALU execute stage: single-cycle arithmetic/logic ops, iterative
// one-bit-per-cycle shifts, valid/ready handshake on both sides.
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ALUControl,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic             illegal
);

    localparam int SW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0010;
    localparam logic [3:0] OP_OR    = 4'b0011;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_SLT   = 4'b0101;
    localparam logic [3:0] OP_SLTU  = 4'b0110;
    localparam logic [3:0] OP_AUIPC = 4'b1000;
    localparam logic [3:0] OP_LUI   = 4'b1001;
    localparam logic [3:0] OP_SLL   = 4'b1010;
    localparam logic [3:0] OP_SRA   = 4'b1011;
    localparam logic [3:0] OP_SRL   = 4'b1100;

    typedef enum logic [1:0] {IDLE, EXEC, SHIFT, DONE} state_t;

    state_t           state_q;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] shreg_q;
    logic [SW-1:0]    cnt_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             illegal_q;

    logic [WIDTH-1:0] res_d;
    logic             ill_d;
    logic [WIDTH-1:0] shift_d;
    logic             is_shift;
    logic [SW-1:0]    shamt;
    logic             lt_s;
    logic             lt_u;

    assign shamt    = b_q[SW-1:0];
    assign is_shift = (op_q == OP_SLL) || (op_q == OP_SRA) || (op_q == OP_SRL);
    assign lt_s     = $signed(a_q) < $signed(b_q);
    assign lt_u     = a_q < b_q;

    // Shift ops resolve to A here; they only use this path when shamt is zero.
    always_comb begin
        res_d = '0;
        ill_d = 1'b0;
        case (op_q)
            OP_ADD, OP_AUIPC: res_d = a_q + b_q;
            OP_SUB:           res_d = a_q - b_q;
            OP_AND:           res_d = a_q & b_q;
            OP_OR:            res_d = a_q | b_q;
            OP_XOR:           res_d = a_q ^ b_q;
            OP_SLT:           res_d = {{(WIDTH-1){1'b0}}, lt_s};
            OP_SLTU:          res_d = {{(WIDTH-1){1'b0}}, lt_u};
            OP_LUI:           res_d = b_q;
            OP_SLL, OP_SRA, OP_SRL: res_d = a_q;
            default: begin
                res_d = '0;
                ill_d = 1'b1;
            end
        endcase
    end

    // The MSB never moves on an arithmetic right shift, so it keeps A's sign.
    always_comb begin
        case (op_q)
            OP_SLL:  shift_d = {shreg_q[WIDTH-2:0], 1'b0};
            OP_SRA:  shift_d = {shreg_q[WIDTH-1], shreg_q[WIDTH-1:1]};
            default: shift_d = {1'b0, shreg_q[WIDTH-1:1]};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            shreg_q   <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            zero_q    <= 1'b1;
            illegal_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        op_q    <= ALUControl;
                        a_q     <= SrcA;
                        b_q     <= SrcB;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    if (is_shift && (shamt != '0)) begin
                        shreg_q <= a_q;
                        cnt_q   <= shamt;
                        state_q <= SHIFT;
                    end else begin
                        result_q  <= res_d;
                        zero_q    <= (res_d == '0);
                        illegal_q <= ill_d;
                        state_q   <= DONE;
                    end
                end
                SHIFT: begin
                    shreg_q <= shift_d;
                    cnt_q   <= cnt_q - 1'b1;
                    if (cnt_q == SW'(1)) begin
                        result_q  <= shift_d;
                        zero_q    <= (shift_d == '0);
                        illegal_q <= 1'b0;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign ALUResult = result_q;
    assign Zero      = zero_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: vector table through a scoreboard
// queue, plus back-pressure, held out_ready and mid-shift reset sequences.
module tb_alu_exec_unit;

    localparam int WIDTH = 32;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        zero;
        logic        ill;
        logic [7:0]  lat;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        ALUControl;
    logic [WIDTH-1:0]  SrcA;
    logic [WIDTH-1:0]  SrcB;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  ALUResult;
    logic              Zero;
    logic              illegal;

    int   total = 0;
    int   bad   = 0;
    vec_t sb[$];
    vec_t vecs[22];

    alu_exec_unit #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ALUControl (ALUControl),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ALUResult  (ALUResult),
        .Zero       (Zero),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input string tag, input vec_t v);
        @(negedge clk);
        in_valid   = 1'b1;
        ALUControl = v.op;
        SrcA       = v.a;
        SrcB       = v.b;
        compare({tag, " in_ready before accept"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        sb.push_back(v);
        #1;
        in_valid   = 1'b0;
        ALUControl = 4'($urandom);
        SrcA       = $urandom;
        SrcB       = $urandom;
    endtask

    task automatic handshake(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        compare({tag, " out_valid after handshake"}, 32'(out_valid), 32'd0);
        compare({tag, " in_ready after handshake"}, 32'(in_ready), 32'd1);
    endtask

    // Called right after applyStimulus; the accept edge counts as latency 1.
    task automatic checkOutput(input string tag, input bit doHandshake);
        int   lat;
        vec_t e;
        lat = 1;
        while (!out_valid && lat < 64) begin
            @(posedge clk);
            lat++;
            #1;
        end
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL %s scoreboard: got empty queue expected an entry", tag);
        end else begin
            e = sb.pop_front();
            compare({tag, " latency"}, 32'(lat), 32'(e.lat));
            compare({tag, " ALUResult"}, ALUResult, e.res);
            compare({tag, " Zero"}, 32'(Zero), 32'(e.zero));
            compare({tag, " illegal"}, 32'(illegal), 32'(e.ill));
        end
        if (doHandshake) handshake(tag);
    endtask

    initial begin
        bit sawValid;

        vecs[0]  = '{op:4'b0000, a:32'h7FFFFFFF, b:32'h1,        res:32'h80000000, zero:1'b0, ill:1'b0, lat:8'd2};
        vecs[1]  = '{op:4'b0001, a:32'h5,        b:32'h5,        res:32'h0,        zero:1'b1, ill:1'b0, lat:8'd2};
        vecs[2]  = '{op:4'b0101, a:32'hFFFFFFFF, b:32'h1,        res:32'h1,        zero:1'b0, ill:1'b0, lat:8'd2};
        vecs[3]  = '{op:4'b0110, a:32'hFFFFFFFF, b:32'h1,        res:32'h0,        zero:1'b1, ill:1'b0, lat:8'd2};
        vecs[4]  = '{op:4'b1001, a:32'hDEADBEEF, b:32'h12345000, res:32'h12345000, zero:1'b0, ill:1'b0, lat:8'd2};
        vecs[5]  = '{op:4'b1000, a:32'h1000,     b:32'h2000,     res:32'h3000,     zero:1'b0, ill:1'b0, lat:8'd2};
        vecs[6]  = '{op:4'b1010, a:32'h80000001, b:32'h4,        res:32'h00000010, zero:1'b0, ill:1'b0, lat:8'd6};
        vecs[7]  = '{op:4'b1100, a:32'h80000001, b:32'h4,        res:32'h08000000, zero:1'b0, ill:1'b0, lat:8'd6};
        vecs[8]  = '{op:4'b1011, a:32'h80000001, b:32'h4,        res:32'hF8000000, zero:1'b0, ill:1'b0, lat:8'd6};
        vecs[9]  = '{op:4'b1010, a:32'h80000001, b:32'h0,        res:32'h80000001, zero:1'b0, ill:1'b0, lat:8'd2};
        vecs[10] = '{op:4'b1011, a:32'h80000001, b:32'd31,       res:32'hFFFFFFFF, zero:1'b0, ill:1'b0, lat:8'd33};
        vecs[11] = '{op:4'b1100, a:32'h80000000, b:32'd31,       res:32'h00000001, zero:1'b0, ill:1'b0, lat:8'd33};
        vecs[12] = '{op:4'b1010, a:32'h80000001, b:32'h24,       res:32'h00000010, zero:1'b0, ill:1'b0, lat:8'd6};
        vecs[13] = '{op:4'b0010, a:32'hF0F0,     b:32'hFF00,     res:32'hF000,     zero:1'b0, ill:1'b0, lat:8'd2};
        vecs[14] = '{op:4'b0011, a:32'hF0F0,     b:32'hFF00,     res:32'hFFF0,     zero:1'b0, ill:1'b0, lat:8'd2};
        vecs[15] = '{op:4'b0100, a:32'hF0F0,     b:32'hFF00,     res:32'h0FF0,     zero:1'b0, ill:1'b0, lat:8'd2};
        vecs[16] = '{op:4'b1110, a:32'h1234,     b:32'h5678,     res:32'h0,        zero:1'b1, ill:1'b1, lat:8'd2};
        vecs[17] = '{op:4'b0000, a:32'h3,        b:32'h4,        res:32'h7,        zero:1'b0, ill:1'b0, lat:8'd2};
        vecs[18] = '{op:4'b0111, a:32'h1,        b:32'h1,        res:32'h0,        zero:1'b1, ill:1'b1, lat:8'd2};
        vecs[19] = '{op:4'b1101, a:32'h1,        b:32'h5,        res:32'h0,        zero:1'b1, ill:1'b1, lat:8'd2};
        vecs[20] = '{op:4'b1111, a:32'h1,        b:32'h5,        res:32'h0,        zero:1'b1, ill:1'b1, lat:8'd2};
        vecs[21] = '{op:4'b0101, a:32'h1,        b:32'hFFFFFFFF, res:32'h0,        zero:1'b1, ill:1'b0, lat:8'd2};

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        ALUControl = 4'h0;
        SrcA       = '0;
        SrcB       = '0;
        #12;
        compare("reset in_ready", 32'(in_ready), 32'd1);
        compare("reset out_valid", 32'(out_valid), 32'd0);
        compare("reset ALUResult", ALUResult, 32'h0);
        compare("reset Zero", 32'(Zero), 32'd1);
        compare("reset illegal", 32'(illegal), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 22; i++) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i]);
            checkOutput($sformatf("vec%0d", i), 1'b1);
        end

        // Back-pressure: result must hold and in_valid pulses must be refused.
        applyStimulus("bp", '{op:4'b0000, a:32'h1, b:32'h2, res:32'h3, zero:1'b0, ill:1'b0, lat:8'd2});
        checkOutput("bp", 1'b0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            in_valid   = c[0];
            ALUControl = 4'b0001;
            SrcA       = $urandom;
            SrcB       = $urandom;
            @(posedge clk);
            #1;
            compare($sformatf("bp%0d out_valid", c), 32'(out_valid), 32'd1);
            compare($sformatf("bp%0d in_ready", c), 32'(in_ready), 32'd0);
            compare($sformatf("bp%0d ALUResult", c), ALUResult, 32'h3);
            compare($sformatf("bp%0d Zero", c), 32'(Zero), 32'd0);
            compare($sformatf("bp%0d illegal", c), 32'(illegal), 32'd0);
        end
        in_valid = 1'b0;
        handshake("bp");
        sawValid = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (out_valid || !in_ready) sawValid = 1'b1;
        end
        compare("bp no phantom op", 32'(sawValid), 32'd0);

        // out_ready held high before and during the op is harmless.
        @(negedge clk);
        out_ready = 1'b1;
        applyStimulus("early_ready", '{op:4'b0100, a:32'hAAAA5555, b:32'hFFFF0000, res:32'h55555555, zero:1'b0, ill:1'b0, lat:8'd2});
        checkOutput("early_ready", 1'b1);

        // Reset in the middle of a 20-bit shift aborts without a result.
        applyStimulus("rst_mid", '{op:4'b1010, a:32'h1, b:32'd20, res:32'h00100000, zero:1'b0, ill:1'b0, lat:8'd22});
        sawValid = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (out_valid) sawValid = 1'b1;
        end
        @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        #1;
        compare("rst_mid in_ready", 32'(in_ready), 32'd1);
        compare("rst_mid ALUResult", ALUResult, 32'h0);
        compare("rst_mid Zero", 32'(Zero), 32'd1);
        compare("rst_mid illegal", 32'(illegal), 32'd0);
        repeat (3) begin
            @(posedge clk);
            #1;
            if (out_valid) sawValid = 1'b1;
        end
        compare("rst_mid out_valid seen", 32'(sawValid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus("after_rst", '{op:4'b0000, a:32'h10, b:32'h20, res:32'h30, zero:1'b0, ill:1'b0, lat:8'd2});
        checkOutput("after_rst", 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
